clk_div_multi: RTL and testbench
================================

# clk_div_multi

Parametrised multi-channel clock divider that replaces the single fixed divider. It generates NUM_CH independent divided clocks from the 100 MHz board clock, each with a one-cycle tick pulse and a 50 % duty toggle output. Each channel has a divisor programmable at run time, a per-channel enable, and a global phase-sync. It sits between the board clock and the processor, display and debug logic that need slow or stepped clocks.

## Interface
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 26: counter and divisor width in bits.
- DEFAULT_DIV, 10000: divisor loaded into every channel at reset.
- CH_W, max(1, clog2(NUM_CH)): channel-select width (derived, not overridden).

Ports:
- Clk  in  1  system clock (100 MHz).
- Rst  in  1  asynchronous, active-high reset.
- WrEn  in  1  divisor write strobe, sampled on posedge Clk.
- WrCh  in  CH_W  channel addressed by the write.
- WrDiv  in  CNT_W  new divisor value.
- ChEn  in  NUM_CH  per-channel run enable.
- Sync  in  1  restarts all channels in phase.
- TickOut  out  NUM_CH  one-cycle pulse per channel period.
- ClkOut  out  NUM_CH  divided clock per channel; toggles on each tick.
- DivActive  out  NUM_CH*CNT_W  active divisor of each channel; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
Each channel holds three registers:
- Cnt, reset value 0.
- DivShadow, reset value DEFAULT_DIV.
- Div (the active divisor), reset value DEFAULT_DIV.

Channel behaviour at each posedge Clk, in priority order:
- **Sync=1:** Cnt<=0, TickOut<=0, ClkOut<=0, Div<=DivShadow. If the same cycle also writes this channel, Div<=WrDiv (write-through).
- **ChEn[i]=0:** Cnt, ClkOut and Div hold; TickOut<=0.
- **Terminal (Cnt>=Div):** Cnt<=0, TickOut<=1, ClkOut<=~ClkOut, Div<=DivShadow. If the same cycle also writes this channel, Div<=WrDiv.
- **Otherwise:** Cnt<=Cnt+1, TickOut<=0.

Writes and divisor rules:
- WrEn=1 with WrCh<NUM_CH sets DivShadow[WrCh]<=WrDiv.
- WrCh>=NUM_CH is ignored and no state changes.
- The active divisor changes only at a terminal count or on Sync, so there are no runt periods.
- The comparison is >=, not ==, so a shrinking divisor can never miss the terminal count.
- Div=0: TickOut stays high continuously and ClkOut toggles every cycle (Clk/2).
- Arithmetic is unsigned. Cnt never exceeds Div, so it cannot wrap. Div=2^CNT_W-1 is legal.

## Timing
- Reset values: every output is 0 except DivActive, which is DEFAULT_DIV on every channel. Reset takes effect immediately (asynchronous); release is synchronous to Clk.
- TickOut period is Div+1 cycles; ClkOut period is 2*(Div+1) cycles with 50 % duty.
- With ChEn high from reset release, the first TickOut is high during cycle Div+1, counting the first edge after release as edge 1.
- All outputs are registered, with no combinational path from any input to any output.
- A write becomes visible in DivActive at the first terminal count after the write edge, or on the same edge when Sync or the terminal count coincides with the write.
- If ChEn drops mid-count and is later raised again, counting resumes from the held Cnt.
- Reset mid-count discards every pending shadow write.

## Structure
- Package clk_div_pkg holds:
  - DEFAULT_DIV_1HZ = 49_999_999 and DEFAULT_DIV_SIM = 10000 constants;
  - a function ch_width(n) returning max(1, clog2(n)).
- Sub-module clk_div_ch implements one channel: Cnt, DivShadow, Div, TickOut and ClkOut, with a local load strobe and load value.
- Top level clk_div_multi decodes the write address and generates NUM_CH instances of clk_div_ch.

## Test plan
- **Reset defaults:** Rst pulse mid-count → all TickOut and ClkOut read 0 immediately and DivActive reads 10000 per channel. With ChEn=4'hF, the first tick is high during cycle 10001.
- **Different periods per channel:** write Div=3 to ch0 and Div=0 to ch1, then pulse Sync.
  - ch0 ticks every 4 cycles and ClkOut toggles with period 8.
  - ch1 TickOut stays high and ClkOut toggles every cycle.
- **Deferred reload:** ch2 runs with Div=9; at Cnt=5, write Div=2.
  - The current period completes at 10 cycles and DivActive changes at that tick.
  - The next period is 3 cycles.
- **Coincident events:**
  - Write Div=7 in the same cycle as Sync → DivActive=7 the next cycle and counting restarts from 0.
  - Write on the terminal cycle → the new value is used for the very next period.
- **Enable gating and illegal write:**
  - ChEn[3]=0 for 20 cycles → no ticks, ClkOut holds, and the count resumes from the held value afterwards.
  - WrCh=5 with NUM_CH=4 → no divisor changes.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and channel-select width helper for clk_div_multi
package clk_div_pkg;
  localparam int DEFAULT_DIV_1HZ = 49_999_999;
  localparam int DEFAULT_DIV_SIM = 10000;
  function automatic int ch_width(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with a shadowed divisor reloaded only at period boundaries
//   en: run enable; sync: restart in phase; load/load_div: shadow divisor write
//   tick: one-cycle pulse per period; clk_out: toggles on every tick; div: active divisor
module clk_div_ch import clk_div_pkg::*; #(
  parameter int CNT_W = 26,
  parameter int DEFAULT_DIV = DEFAULT_DIV_SIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             clk_out,
  output logic [CNT_W-1:0] div
);
  logic [CNT_W-1:0] cnt, shadow, next_div;
  // a write landing on a reload edge bypasses the shadow so it takes effect immediately
  assign next_div = load ? load_div : shadow;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      shadow  <= CNT_W'(DEFAULT_DIV);
      div     <= CNT_W'(DEFAULT_DIV);
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      if (load) shadow <= load_div;
      if (sync) begin
        cnt     <= '0;
        tick    <= 1'b0;
        clk_out <= 1'b0;
        div     <= next_div;
      end else if (!en) tick <= 1'b0;
      else if (cnt >= div) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= ~clk_out;
        div     <= next_div;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable clock dividers with global phase sync
//   wr_en/wr_ch/wr_div: divisor write (out-of-range channel ignored); ch_en: per-channel run
//   sync: restart all channels; tick_out/clk_out: per-channel pulse and 50% clock
//   div_active: active divisors, channel i at [i*CNT_W +: CNT_W]
module clk_div_multi import clk_div_pkg::*; #(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = 26,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_SIM,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [CNT_W-1:0]        wr_div,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       tick_out,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH*CNT_W-1:0] div_active
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (ch_en[i]),
      .sync     (sync),
      .load     (wr_en && wr_ch == CH_W'(i)),
      .load_div (wr_div),
      .tick     (tick_out[i]),
      .clk_out  (clk_out[i]),
      .div      (div_active[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed period/reload/gating checks plus random traffic against a countdown model
module tb_clk_div_multi;
  // five channels so the 3-bit select can name channels that do not exist (5..7)
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 26;
  localparam int DEF    = 10000;
  localparam int CH_W   = 3;
  typedef logic [NUM_CH*CNT_W-1:0] vec_t;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, sync = 1'b0;
  logic [CH_W-1:0] wr_ch = '0;
  logic [CNT_W-1:0] wr_div = '0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic [NUM_CH-1:0] tick_out, clk_out;
  vec_t div_active;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_div     (wr_div),
    .ch_en      (ch_en),
    .sync       (sync),
    .tick_out   (tick_out),
    .clk_out    (clk_out),
    .div_active (div_active)
  );
  task automatic check(input string tag, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference: each channel counts down the enabled edges left in its period; clock is tick parity
  logic [CNT_W-1:0] m_act[NUM_CH], m_sh[NUM_CH];
  longint m_rem[NUM_CH];
  int m_nt[NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_act[c] = CNT_W'(DEF);
        m_sh[c] = CNT_W'(DEF);
        m_rem[c] = DEF + 1;
        m_nt[c] = 0;
        m_tick[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        logic hit;
        logic [CNT_W-1:0] nxt;
        hit = wr_en && int'(wr_ch) == c;
        nxt = hit ? wr_div : m_sh[c];
        m_tick[c] = 1'b0;
        if (sync) begin
          m_act[c] = nxt;
          m_rem[c] = longint'(nxt) + 1;
          m_nt[c] = 0;
        end else if (ch_en[c]) begin
          m_rem[c]--;
          if (m_rem[c] == 0) begin
            m_tick[c] = 1'b1;
            m_nt[c]++;
            m_act[c] = nxt;
            m_rem[c] = longint'(nxt) + 1;
          end
        end
        if (hit) m_sh[c] = wr_div;
      end
    end
  always @(negedge clk)
    if (!rst) begin
      logic [NUM_CH-1:0] ec;
      vec_t ed;
      for (int c = 0; c < NUM_CH; c++) begin
        ec[c] = m_nt[c][0];
        ed[c*CNT_W +: CNT_W] = m_act[c];
      end
      check("model_tick", vec_t'(tick_out), vec_t'(m_tick));
      check("model_clk", vec_t'(clk_out), vec_t'(ec));
      check("model_div", div_active, ed);
    end
  initial begin
    logic [63:0] p0, c0, p1, c1, p2, p3, c3, e0, e1, e2, e3;
    logic [CNT_W-1:0] d9, d10, d3, da, db;
    int n;
    repeat (3) @(negedge clk);
    check("rst_tick", vec_t'(tick_out), '0);
    check("rst_clk", vec_t'(clk_out), '0);
    check("rst_div", div_active, {NUM_CH{CNT_W'(DEF)}});
    rst = 1'b0;
    ch_en = '1;
    // ch0 div 3, ch1 div 0, then restart in phase
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = CNT_W'(3); @(negedge clk);
    wr_ch = 3'd1; wr_div = CNT_W'(0); @(negedge clk);
    wr_en = 1'b0; sync = 1'b1; @(negedge clk);
    sync = 1'b0;
    {p0, c0, p1, c1, e0, e1, e2, e3} = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      p0[k] = tick_out[0]; c0[k] = clk_out[0]; p1[k] = tick_out[1]; c1[k] = clk_out[1];
      e0[k] = (k % 4 == 0); e1[k] = ((k / 4) % 2 == 1); e2[k] = 1'b1; e3[k] = (k % 2 == 1);
    end
    check("div3_tick", vec_t'(p0), vec_t'(e0));
    check("div3_clk", vec_t'(c0), vec_t'(e1));
    check("div0_tick", vec_t'(p1), vec_t'(e2));
    check("div0_clk", vec_t'(c1), vec_t'(e3));
    // ch2 div 9 via write-through sync, shrink to 2 when its count reads 5
    wr_en = 1'b1; wr_ch = 3'd2; wr_div = CNT_W'(9); sync = 1'b1; @(negedge clk);
    wr_en = 1'b0; sync = 1'b0;
    {p2, e0} = '0;
    {d9, d10} = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      p2[k] = tick_out[2];
      e0[k] = (k == 10 || k == 13 || k == 16);
      if (k == 9) d9 = div_active[2*CNT_W +: CNT_W];
      if (k == 10) d10 = div_active[2*CNT_W +: CNT_W];
      if (k == 5) begin wr_en = 1'b1; wr_ch = 3'd2; wr_div = CNT_W'(2); end
    end
    check("defer_tick", vec_t'(p2), vec_t'(e0));
    check("defer_div_before", vec_t'(d9), vec_t'(CNT_W'(9)));
    check("defer_div_at_tick", vec_t'(d10), vec_t'(CNT_W'(2)));
    // write ch3 with sync; write ch0 on its terminal edge; gate ch3 for 20 cycles
    wr_en = 1'b1; wr_ch = 3'd3; wr_div = CNT_W'(7); sync = 1'b1; @(negedge clk);
    wr_en = 1'b0; sync = 1'b0;
    {p0, p3, c3, e0, e1, e2} = '0;
    {d3, da, db} = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      p0[k] = tick_out[0]; p3[k] = tick_out[3]; c3[k] = clk_out[3];
      e0[k] = (k == 4) || (k >= 10 && (k - 4) % 6 == 0);
      e1[k] = (k == 8 || k == 36);
      e2[k] = (k >= 8 && k <= 35);
      if (k == 1) d3 = div_active[3*CNT_W +: CNT_W];
      if (k == 3) begin da = div_active[CNT_W-1:0]; wr_en = 1'b1; wr_ch = 3'd0; wr_div = CNT_W'(5); end
      if (k == 4) db = div_active[CNT_W-1:0];
      if (k == 12) ch_en[3] = 1'b0;
      if (k == 32) ch_en[3] = 1'b1;
    end
    check("sync_write_div", vec_t'(d3), vec_t'(CNT_W'(7)));
    check("term_write_old", vec_t'(da), vec_t'(CNT_W'(3)));
    check("term_write_new", vec_t'(db), vec_t'(CNT_W'(5)));
    check("term_write_tick", vec_t'(p0), vec_t'(e0));
    check("gate_tick", vec_t'(p3), vec_t'(e1));
    check("gate_clk", vec_t'(c3), vec_t'(e2));
    // writes to nonexistent channels must leave every divisor alone
    wr_en = 1'b1; wr_ch = 3'd5; wr_div = CNT_W'(123); @(negedge clk);
    wr_ch = 3'd7; @(negedge clk);
    wr_en = 1'b0; sync = 1'b1; @(negedge clk);
    sync = 1'b0;
    check("illegal_wr", div_active, {CNT_W'(DEF), CNT_W'(7), CNT_W'(2), CNT_W'(0), CNT_W'(5)});
    // pending shadow write on ch4, then asynchronous reset mid-cycle
    wr_en = 1'b1; wr_ch = 3'd4; wr_div = CNT_W'(20); @(negedge clk);
    wr_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_tick", vec_t'(tick_out), '0);
    check("arst_clk", vec_t'(clk_out), '0);
    check("arst_div", div_active, {NUM_CH{CNT_W'(DEF)}});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_out[0] && n < 20000);
    check("first_tick_cycle", vec_t'(n), vec_t'(DEF + 1));
    check("first_tick_all", vec_t'(tick_out), vec_t'({NUM_CH{1'b1}}));
    check("shadow_discarded", div_active, {NUM_CH{CNT_W'(DEF)}});
    // random traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_ch = CH_W'($urandom_range(0, 7));
      wr_div = ($urandom_range(0, 50) == 0) ? '1 : CNT_W'($urandom_range(0, 12));
      ch_en = ~(NUM_CH'($urandom) & NUM_CH'($urandom));
      sync = ($urandom_range(0, 60) == 0);
      @(negedge clk);
    end
    wr_en = 1'b0;
    sync = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
